datapath_gray2rgb: RTL and testbench

DATAPATH_GRAY2RGB -- requirements
Module: datapath_gray2rgb

---
 rtl/datapath_gray2rgb_pkg.sv | 34 +++
 rtl/datapath_gray2rgb_stream_fifo.sv | 54 +++++
 rtl/datapath_gray2rgb.sv | 134 +++++++++++++
 tb/tb_datapath_gray2rgb.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_gray2rgb_pkg.sv
// Shared types and constants for the gray-to-RGB byte serializer.
// Define DATAPATH_GRAY2RGB_PSEUDOCOLOR_EN to build the pseudocolour mapping instead of plain gray.
package datapath_gray2rgb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EMIT_R = 2'd1,
      ST_EMIT_G = 2'd2,
      ST_EMIT_B = 2'd3
   } state_t;

   // FIFO entry layout is {gray[7:0], sof}
   localparam int ENTRY_W = 9;

   localparam logic [1:0] IDX_R = 2'd0;
   localparam logic [1:0] IDX_G = 2'd1;
   localparam logic [1:0] IDX_B = 2'd2;

   function automatic logic [7:0] color_byte(input logic [7:0] g, input logic [1:0] idx);
      logic [7:0] c;
`ifdef DATAPATH_GRAY2RGB_PSEUDOCOLOR_EN
      case (idx)
         IDX_R:   c = g[7] ? 8'hFF : {g[6:0], 1'b0};
         IDX_G:   c = g;
         default: c = ~g;
      endcase
`else
      c = g;
      if (idx == 2'd3) c = 8'h00;
`endif
      return c;
   endfunction

endpackage

// File: rtl/datapath_gray2rgb_stream_fifo.sv
// Small synchronous FIFO with combinational read of the head entry.
// Depth must be a power of two so the pointers wrap naturally.
module stream_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/datapath_gray2rgb.sv
// Gray pixel in, three colour bytes (R, G, B) out, valid/busy handshakes on both sides.
// Define DATAPATH_GRAY2RGB_PSEUDOCOLOR_EN to select the pseudocolour mapping.
module datapath_gray2rgb
   import datapath_gray2rgb_pkg::*;
#(
   parameter int C_FIFO_DEPTH = 2
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   input  logic       sof_in,
   output logic       busy_out,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       sof_out,
   input  logic       busy_in,
   output logic [1:0] dbg_state
);

   // Handshake: a beat moves on a rising edge when the source's valid is high and the
   // sink's busy is low; while valid is high and busy is high, the source holds everything.

   state_t               state;
   state_t               state_nxt;
   logic [7:0]           pix_q;
   logic [7:0]           pix_nxt;
   logic [7:0]           data_nxt;
   logic                 valid_nxt;
   logic                 sof_nxt;
   logic                 fifo_pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [ENTRY_W-1:0]   fifo_dout;
   logic [7:0]           head_g;
   logic                 head_sof;
   logic                 xfer;

   assign busy_out  = fifo_full;
   assign xfer      = valid_out && !busy_in;
   assign head_g    = fifo_dout[ENTRY_W-1:1];
   assign head_sof  = fifo_dout[0];
   assign dbg_state = state;

   stream_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (C_FIFO_DEPTH)
   ) u_fifo (
      .clk   (i_clk),
      .rst   (i_rst),
      .push  (valid_in && !fifo_full),
      .pop   (fifo_pop),
      .din   ({data_in, sof_in}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state     <= ST_IDLE;
         pix_q     <= 8'h00;
         data_out  <= 8'h00;
         valid_out <= 1'b0;
         sof_out   <= 1'b0;
      end else begin
         state     <= state_nxt;
         pix_q     <= pix_nxt;
         data_out  <= data_nxt;
         valid_out <= valid_nxt;
         sof_out   <= sof_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pix_nxt   = pix_q;
      data_nxt  = data_out;
      valid_nxt = valid_out;
      sof_nxt   = sof_out;
      fifo_pop  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               pix_nxt   = head_g;
               state_nxt = ST_EMIT_R;
               data_nxt  = color_byte(head_g, IDX_R);
               sof_nxt   = head_sof;
               valid_nxt = 1'b1;
            end
         end
         ST_EMIT_R: begin
            if (xfer) begin
               state_nxt = ST_EMIT_G;
               data_nxt  = color_byte(pix_q, IDX_G);
               sof_nxt   = 1'b0;
            end
         end
         ST_EMIT_G: begin
            if (xfer) begin
               state_nxt = ST_EMIT_B;
               data_nxt  = color_byte(pix_q, IDX_B);
               sof_nxt   = 1'b0;
            end
         end
         ST_EMIT_B: begin
            // Chain straight into the next pixel so a busy-free stream has no bubble.
            if (xfer) begin
               if (!fifo_empty) begin
                  fifo_pop  = 1'b1;
                  pix_nxt   = head_g;
                  state_nxt = ST_EMIT_R;
                  data_nxt  = color_byte(head_g, IDX_R);
                  sof_nxt   = head_sof;
                  valid_nxt = 1'b1;
               end else begin
                  state_nxt = ST_IDLE;
                  data_nxt  = 8'h00;
                  sof_nxt   = 1'b0;
                  valid_nxt = 1'b0;
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            valid_nxt = 1'b0;
            sof_nxt   = 1'b0;
            data_nxt  = 8'h00;
         end
      endcase
   end

endmodule

// File: tb/tb_datapath_gray2rgb.sv
// Bench for datapath_gray2rgb: directed handshake/reset cases plus a randomized backpressure run.
// Honours DATAPATH_GRAY2RGB_PSEUDOCOLOR_EN in its reference colour mapping.
module tb_datapath_gray2rgb;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       valid_in = 1'b0;
   logic       sof_in = 1'b0;
   logic       busy_out;
   logic [7:0] data_out;
   logic       valid_out;
   logic       sof_out;
   logic       busy_in = 1'b0;
   logic [1:0] dbg_state;

   int         n_vec = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         xfer_cnt = 0;
   int         first_cyc = -1;
   int         last_cyc = -1;
   bit         saw_busy = 0;
   bit         rand_busy = 0;

   logic [8:0] exp_q[$];

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_R    = 2'd1;
   localparam logic [1:0] S_G    = 2'd2;

   datapath_gray2rgb dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .sof_in    (sof_in),
      .busy_out  (busy_out),
      .data_out  (data_out),
      .valid_out (valid_out),
      .sof_out   (sof_out),
      .busy_in   (busy_in),
      .dbg_state (dbg_state)
   );

   // clock / reset
   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: sim time exceeded, actual=running required=finished");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] ref_col(input logic [7:0] g, input int idx);
`ifdef DATAPATH_GRAY2RGB_PSEUDOCOLOR_EN
      if (idx == 0) return (g >= 8'd128) ? 8'hFF : (g << 1);
      if (idx == 1) return g;
      return 8'hFF - g;
`else
      return g;
`endif
   endfunction

   // scoreboard: push three expected bytes per accepted pixel, pop one per output transfer
   always @(negedge i_clk) begin
      if (!i_rst) begin
         exp_q.delete();
      end else begin
         if (busy_out) saw_busy = 1;
         if (valid_in && !busy_out) begin
            exp_q.push_back({sof_in, ref_col(data_in, 0)});
            exp_q.push_back({1'b0, ref_col(data_in, 1)});
            exp_q.push_back({1'b0, ref_col(data_in, 2)});
         end
         if (valid_out && !busy_in) begin
            xfer_cnt++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            if (exp_q.size() == 0) check("sb_extra_byte", {7'd0, sof_out, data_out}, 16'hFFFF);
            else check("sb_byte", {7'd0, sof_out, data_out}, {7'd0, exp_q.pop_front()});
         end
      end
   end

   always @(posedge i_clk) begin
      if (rand_busy) begin
         #1;
         busy_in = 1'($urandom_range(0, 1));
      end
   end

   // driver tasks (called at posedge + 1)
   task automatic send_pixel(input logic [7:0] g, input logic s);
      int n;
      bit acc;
      data_in  = g;
      sof_in   = s;
      valid_in = 1'b1;
      n = 0;
      acc = 0;
      while (!acc && n < 100) begin
         @(negedge i_clk);
         acc = !busy_out && i_rst;
         @(posedge i_clk);
         #1;
         n++;
      end
      valid_in = 1'b0;
      sof_in   = 1'b0;
      if (!acc) check("send_timeout", 16'd0, 16'd1);
   endtask

   task automatic wait_state(input logic [1:0] st, input string tag);
      int n;
      bit hit;
      n = 0;
      hit = 0;
      while (!hit && n < 50) begin
         @(negedge i_clk);
         hit = (dbg_state == st);
         n++;
      end
      if (!hit) check(tag, {14'd0, dbg_state}, {14'd0, st});
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(posedge i_clk);
         n++;
      end
      repeat (4) @(posedge i_clk);
      #1;
      check(tag, 16'(exp_q.size()), 16'd0);
   endtask

   task automatic clear_stats();
      xfer_cnt = 0;
      first_cyc = -1;
      last_cyc = -1;
      saw_busy = 0;
   endtask

   initial begin
      // reset state
      i_rst = 1'b0;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      check("rst_valid_out", {15'd0, valid_out}, 16'd0);
      check("rst_sof_out", {15'd0, sof_out}, 16'd0);
      check("rst_data_out", {8'd0, data_out}, 16'h0000);
      check("rst_busy_out", {15'd0, busy_out}, 16'd0);
      check("rst_state", {14'd0, dbg_state}, {14'd0, S_IDLE});
      @(posedge i_clk);
      #1;
      i_rst = 1'b1;
      repeat (2) @(posedge i_clk);
      #1;

      // single pixel latency and byte order
      send_pixel(8'h5A, 1'b1);
      @(negedge i_clk);
      check("lat_not_yet", {15'd0, valid_out}, 16'd0);
      @(negedge i_clk);
      check("lat_r", {6'd0, valid_out, sof_out, data_out}, {6'd0, 1'b1, 1'b1, ref_col(8'h5A, 0)});
      @(negedge i_clk);
      check("lat_g", {6'd0, valid_out, sof_out, data_out}, {6'd0, 1'b1, 1'b0, ref_col(8'h5A, 1)});
      @(negedge i_clk);
      check("lat_b", {6'd0, valid_out, sof_out, data_out}, {6'd0, 1'b1, 1'b0, ref_col(8'h5A, 2)});
      @(negedge i_clk);
      check("lat_done", {15'd0, valid_out}, 16'd0);
      @(posedge i_clk);
      #1;
      drain("drain_single");

      // back-to-back pixels: contiguous nine bytes, FIFO fills
      clear_stats();
      send_pixel(8'h10, 1'b0);
      send_pixel(8'h20, 1'b0);
      send_pixel(8'h30, 1'b0);
      drain("drain_b2b");
      check("b2b_count", 16'(xfer_cnt), 16'd9);
      check("b2b_contig", 16'(last_cyc - first_cyc), 16'd8);
      check("b2b_busy_seen", {15'd0, saw_busy}, 16'd1);

      // downstream stall during the G byte
      clear_stats();
      send_pixel(8'h77, 1'b0);
      wait_state(S_R, "stall_reach_r");
      @(posedge i_clk);
      #1;
      busy_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge i_clk);
         check("stall_hold", {5'd0, dbg_state, valid_out, data_out}, {5'd0, S_G, 1'b1, ref_col(8'h77, 1)});
      end
      @(posedge i_clk);
      #1;
      busy_in = 1'b0;
      drain("drain_stall");
      check("stall_count", 16'(xfer_cnt), 16'd3);

`ifdef DATAPATH_GRAY2RGB_PSEUDOCOLOR_EN
      // pseudocolour spot values, independent of the reference function
      clear_stats();
      send_pixel(8'h40, 1'b0);
      repeat (2) @(negedge i_clk);
      check("pc_40_r", {8'd0, data_out}, 16'h0080);
      @(negedge i_clk);
      check("pc_40_g", {8'd0, data_out}, 16'h0040);
      @(negedge i_clk);
      check("pc_40_b", {8'd0, data_out}, 16'h00BF);
      @(posedge i_clk);
      #1;
      drain("drain_pc1");
      send_pixel(8'hC0, 1'b0);
      repeat (2) @(negedge i_clk);
      check("pc_c0_r", {8'd0, data_out}, 16'h00FF);
      @(negedge i_clk);
      check("pc_c0_g", {8'd0, data_out}, 16'h00C0);
      @(negedge i_clk);
      check("pc_c0_b", {8'd0, data_out}, 16'h003F);
      @(posedge i_clk);
      #1;
      drain("drain_pc2");
`endif

      // reset in the middle of a pixel with another one queued
      send_pixel(8'h33, 1'b1);
      send_pixel(8'h44, 1'b0);
      wait_state(S_R, "rst_reach_r");
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      @(posedge i_clk);
      @(negedge i_clk);
      check("mid_rst_valid", {15'd0, valid_out}, 16'd0);
      check("mid_rst_busy", {15'd0, busy_out}, 16'd0);
      check("mid_rst_state", {14'd0, dbg_state}, {14'd0, S_IDLE});
      @(posedge i_clk);
      #1;
      i_rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge i_clk);
         check("post_rst_quiet", {15'd0, valid_out}, 16'd0);
      end
      @(posedge i_clk);
      #1;
      clear_stats();
      send_pixel(8'h66, 1'b1);
      drain("drain_post_rst");
      check("post_rst_count", 16'(xfer_cnt), 16'd3);

      // FIFO full while downstream is stalled: input ignored, outputs frozen
      clear_stats();
      busy_in = 1'b1;
      send_pixel(8'hA1, 1'b1);
      send_pixel(8'hA2, 1'b0);
      send_pixel(8'hA3, 1'b0);
      data_in  = 8'hA4;
      valid_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge i_clk);
         check("full_busy", {15'd0, busy_out}, 16'd1);
         check("full_frozen", {5'd0, dbg_state, valid_out, data_out}, {5'd0, S_R, 1'b1, ref_col(8'hA1, 0)});
         @(posedge i_clk);
         #1;
      end
      valid_in = 1'b0;
      busy_in  = 1'b0;
      drain("drain_full");
      check("full_count", 16'(xfer_cnt), 16'd9);

      // randomized traffic with random downstream backpressure
      rand_busy = 1;
      for (int i = 0; i < 24; i++) begin
         send_pixel(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 4)) @(posedge i_clk);
            #1;
         end
      end
      rand_busy = 0;
      @(posedge i_clk);
      #2;
      busy_in = 1'b0;
      drain("drain_random");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
